// File: rtl/piso_reader.sv
// piso_reader: loads a 74HC165-style chain and shifts NBITS bits back in, MSB first.
// Define PISO_CE_EN to add the registered sft_ce_n chain clock-enable output.
module piso_reader #(
  parameter int NBITS = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] dout,
  output logic             sft_pl_n,
  output logic             sft_cp,
  input  logic             sft_q7
`ifdef PISO_CE_EN
  ,
  output logic             sft_ce_n
`endif
);
  localparam int PW = $clog2(DIV + 1);
  localparam int BW = $clog2(NBITS);
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, LOW, HIGH, DONE} state_t;
  state_t           state_q;
  logic [PW-1:0]    ph_q;
  logic [BW-1:0]    bit_q;
  logic [NBITS-1:0] shreg_q, dout_q;
  logic             busy_q, done_q, pl_n_q, cp_q;
`ifdef PISO_CE_EN
  logic             ce_n_q;
  assign sft_ce_n = ce_n_q;
`endif
  logic             last;
  assign last     = ph_q == PW'(DIV - 1);
  assign busy     = busy_q;
  assign done     = done_q;
  assign dout     = dout_q;
  assign sft_pl_n = pl_n_q;
  assign sft_cp   = cp_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pl_n_q  <= 1'b1;
      cp_q    <= 1'b0;
`ifdef PISO_CE_EN
      ce_n_q  <= 1'b1;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (vld) begin
          state_q <= LOAD;
          ph_q    <= '0;
          pl_n_q  <= 1'b0;
          busy_q  <= 1'b1;
        end
        LOAD: if (last) begin
          state_q <= HOLD;
          ph_q    <= '0;
          pl_n_q  <= 1'b1;
`ifdef PISO_CE_EN
          ce_n_q  <= 1'b0;
`endif
        end else ph_q <= ph_q + 1'b1;
        HOLD: if (last) begin
          state_q <= LOW;
          ph_q    <= '0;
          bit_q   <= '0;
        end else ph_q <= ph_q + 1'b1;
        LOW: if (last) begin
          ph_q    <= '0;
          shreg_q <= {shreg_q[NBITS-2:0], sft_q7};
          if (bit_q == BW'(NBITS - 1)) begin
            state_q <= DONE;
            dout_q  <= {shreg_q[NBITS-2:0], sft_q7};
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
`ifdef PISO_CE_EN
            ce_n_q  <= 1'b1;
`endif
          end else begin
            state_q <= HIGH;
            bit_q   <= bit_q + 1'b1;
            cp_q    <= 1'b1;
          end
        end else ph_q <= ph_q + 1'b1;
        HIGH: if (last) begin
          state_q <= LOW;
          ph_q    <= '0;
          cp_q    <= 1'b0;
        end else ph_q <= ph_q + 1'b1;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_reader.sv
// tb_piso_reader: drives piso_reader against a behavioural 74HC165 chain and checks word, timing and strobes.
module tb_piso_reader;
  localparam int D8    = 4;
  localparam int LAT8  = 2 * D8 + (2 * 8 - 1) * D8 + 1;
  localparam int LAT16 = 2 * 1 + (2 * 16 - 1) * 1 + 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic vld8 = 1'b0, vld16 = 1'b0;
  logic busy8, done8, pl_n8, cp8, busy16, done16, pl_n16, cp16;
  logic [7:0]  dout8;
  logic [15:0] dout16;
  logic [7:0]  load8 = '0, chain8 = '0;
  logic [15:0] load16 = '0, chain16 = '0;
  logic cp8_d = 1'b0, cp16_d = 1'b0;
  logic junk_mode = 1'b0, q7_drv = 1'b0;
  logic q7_8, q7_16;
`ifdef PISO_CE_EN
  logic ce8, ce16;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign q7_8  = junk_mode ? q7_drv : chain8[7];
  assign q7_16 = chain16[15];
  piso_reader u8 (
    .clk(clk), .rst_n(rst_n), .vld(vld8), .busy(busy8), .done(done8), .dout(dout8),
    .sft_pl_n(pl_n8), .sft_cp(cp8), .sft_q7(q7_8)
`ifdef PISO_CE_EN
    , .sft_ce_n(ce8)
`endif
  );
  piso_reader #(.NBITS(16), .DIV(1)) u16 (
    .clk(clk), .rst_n(rst_n), .vld(vld16), .busy(busy16), .done(done16), .dout(dout16),
    .sft_pl_n(pl_n16), .sft_cp(cp16), .sft_q7(q7_16)
`ifdef PISO_CE_EN
    , .sft_ce_n(ce16)
`endif
  );
  // external shift-register chains: load while PL low, shift on CP rising edge
  always @(posedge clk) begin
    if (!pl_n8) chain8 <= load8;
    else if (cp8 && !cp8_d) chain8 <= chain8 << 1;
    cp8_d <= cp8;
    if (!pl_n16) chain16 <= load16;
    else if (cp16 && !cp16_d) chain16 <= chain16 << 1;
    cp16_d <= cp16;
  end
  function automatic logic q7_for(input logic [7:0] v, input int k);
    q7_for = 1'($urandom);
    for (int b = 0; b < 8; b++)
      if (k == 2 * D8 + (2 * b + 1) * D8) q7_for = v[7-b];
  endfunction
  task automatic do_read8(input logic [7:0] val, input logic junk, output int done_cyc,
                          output logic [7:0] dq, output int pl_low, output int cp_edges,
                          output int busy_bad, output int ce_bad);
    logic cp_prev;
    load8 = val; junk_mode = junk; done_cyc = -1; dq = '0;
    pl_low = 0; cp_edges = 0; busy_bad = 0; ce_bad = 0; cp_prev = 1'b0;
    @(negedge clk);
    vld8 = 1'b1;
    @(negedge clk);
    vld8 = 1'b0;
    for (int k = 1; k <= LAT8 + 30; k++) begin
      if (junk) q7_drv = q7_for(val, k);
      if (!pl_n8) pl_low++;
      if (cp8 && !cp_prev) cp_edges++;
      cp_prev = cp8;
      if (busy8 !== (k < LAT8)) busy_bad++;
`ifdef PISO_CE_EN
      if (ce8 !== !(k > D8 && k < LAT8)) ce_bad++;
`endif
      if (done8) begin
        done_cyc = k;
        dq = dout8;
        break;
      end
      @(negedge clk);
    end
    junk_mode = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 5;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done8); end
    if (dout8 !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout8); end
    if (pl_n8 !== 1'b1) begin bad++; $display("FAIL reset_pl_n got=%b exp=1", pl_n8); end
    if (cp8 !== 1'b0) begin bad++; $display("FAIL reset_cp got=%b exp=0", cp8); end
`ifdef PISO_CE_EN
    total++;
    if (ce8 !== 1'b1) begin bad++; $display("FAIL reset_ce_n got=%b exp=1", ce8); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_read(input logic [7:0] val, input logic junk, input string nm);
    int dc, pl, ce, bb, ceb;
    logic [7:0] dq;
    do_read8(val, junk, dc, dq, pl, ce, bb, ceb);
    total += 5;
    if (dq !== val) begin bad++; $display("FAIL %s_dout got=%h exp=%h", nm, dq, val); end
    if (dc != LAT8) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", nm, dc, LAT8); end
    if (pl != D8) begin bad++; $display("FAIL %s_pl_low got=%0d exp=%0d", nm, pl, D8); end
    if (ce != 7) begin bad++; $display("FAIL %s_cp_edges got=%0d exp=7", nm, ce); end
    if (bb != 0) begin bad++; $display("FAIL %s_busy bad_cycles=%0d exp=0", nm, bb); end
`ifdef PISO_CE_EN
    total++;
    if (ceb != 0) begin bad++; $display("FAIL %s_ce_n bad_cycles=%0d exp=0", nm, ceb); end
`endif
  endtask
  task automatic test_basic;
    test_read(8'hA5, 1'b0, "basic_a5");
    repeat (3) test_read(8'($urandom), 1'b0, "basic_rand");
  endtask
  task automatic test_sample_point;
    repeat (4) test_read(8'($urandom), 1'b1, "sample_pt");
  endtask
  task automatic test_back_to_back;
    int ndone, d1, d2;
    logic [7:0] val, o1, o2;
    val = 8'($urandom) | 8'h01;
    load8 = val; ndone = 0; d1 = -1; d2 = -1; o1 = '0; o2 = '0;
    @(negedge clk);
    vld8 = 1'b1;
    for (int k = 1; k <= 2 * LAT8 + 40; k++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        if (ndone == 1) begin d1 = k; o1 = dout8; end
        if (ndone == 2) begin d2 = k; o2 = dout8; end
      end
      vld8 = (k <= LAT8 + 1);
    end
    vld8 = 1'b0;
    total += 5;
    if (ndone != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", ndone); end
    if (d1 != LAT8) begin bad++; $display("FAIL b2b_first got=%0d exp=%0d", d1, LAT8); end
    if (d2 != 2 * LAT8 + 1) begin bad++; $display("FAIL b2b_second got=%0d exp=%0d", d2, 2 * LAT8 + 1); end
    if (o1 !== val) begin bad++; $display("FAIL b2b_dout1 got=%h exp=%h", o1, val); end
    if (o2 !== val) begin bad++; $display("FAIL b2b_dout2 got=%h exp=%h", o2, val); end
  endtask
  task automatic test_async_reset;
    logic [7:0] pre;
    pre = dout8;
    load8 = 8'h5A;
    @(negedge clk);
    vld8 = 1'b1;
    @(negedge clk);
    vld8 = 1'b0;
    repeat (2 * D8 + 7 * D8 + 1) @(negedge clk);
    total++;
    if (cp8 !== 1'b1) begin bad++; $display("FAIL rst_in_high cp got=%b exp=1", cp8); end
    rst_n = 1'b0;
    #1;
    total += 5;
    if (cp8 !== 1'b0) begin bad++; $display("FAIL rst_cp got=%b exp=0", cp8); end
    if (pl_n8 !== 1'b1) begin bad++; $display("FAIL rst_pl_n got=%b exp=1", pl_n8); end
    if (busy8 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy8); end
    if (dout8 !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h exp=00 (was %h)", dout8, pre); end
    if (done8 !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done8); end
    @(negedge clk);
    rst_n = 1'b1;
    test_read(8'h3C, 1'b0, "after_rst");
  endtask
  task automatic test_wide_fast(input logic [15:0] val);
    int dc, edges, gap_bad, last_rise;
    logic cp_prev;
    logic [15:0] dq;
    load16 = val; dc = -1; edges = 0; gap_bad = 0; last_rise = -1; cp_prev = 1'b0; dq = '0;
    @(negedge clk);
    vld16 = 1'b1;
    @(negedge clk);
    vld16 = 1'b0;
    for (int k = 1; k <= LAT16 + 20; k++) begin
      if (cp16 && !cp_prev) begin
        edges++;
        if (last_rise >= 0 && k - last_rise != 2) gap_bad++;
        last_rise = k;
      end
      cp_prev = cp16;
      if (done16) begin dc = k; dq = dout16; break; end
      @(negedge clk);
    end
    total += 4;
    if (dq !== val) begin bad++; $display("FAIL wide_dout got=%h exp=%h", dq, val); end
    if (dc != LAT16) begin bad++; $display("FAIL wide_latency got=%0d exp=%0d", dc, LAT16); end
    if (edges != 15) begin bad++; $display("FAIL wide_cp_edges got=%0d exp=15", edges); end
    if (gap_bad != 0) begin bad++; $display("FAIL wide_cp_period bad_gaps=%0d exp=0", gap_bad); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_sample_point;
    test_back_to_back;
    test_async_reset;
    test_wide_fast(16'h1234);
    test_wide_fast(16'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
